// File: rtl/bank_done_arbiter_pkg.sv
// Types and constants shared by the bank back-end completion path and the
// mapper's bank dispatch.
package types_def;

    localparam int read_entries_log = 6;
    localparam int num_banks        = 16;
    localparam int bank_data_width  = 32;

    typedef enum logic {
        req_read  = 1'b0,
        req_write = 1'b1
    } req_type_e;

    typedef struct packed {
        logic                        req_type;
        logic [bank_data_width-1:0]  data;
        logic [read_entries_log-1:0] index;
    } bank_done_t;

    function automatic bit is_pow2(input int n);
        return (n > 0) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/bank_done_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: the lowest requester at or above ptr
// wins, wrapping around through a double-width masked search.
module rr_arbiter #(
    parameter int N = 16,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] grant,
    output logic [W-1:0] grant_idx
);

    logic [N-1:0]   hi_mask;
    logic [2*N-1:0] dbl_req;

    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        hi_mask   = '0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < N; i++) begin
            hi_mask[i] = (i >= int'(ptr));
        end
        // Upper copy holds all requests, lower copy only those at/after ptr.
        dbl_req = {req, req & hi_mask};
        for (int i = 2 * N - 1; i >= 0; i--) begin
            if (dbl_req[i]) begin
                grant_idx = i[W-1:0];
            end
        end
        if (|req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bank_done_arbiter.sv
// One-deep completion slot per bank, drained by a fair round-robin arbiter
// into a single registered completion stream towards the returner.
module bank_done_arbiter #(
    parameter int data_width  = 32,
    parameter int num_banks   = types_def::num_banks,
    parameter int index_width = types_def::read_entries_log
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [num_banks-1:0]              bank_done_valid,
    input  logic [num_banks-1:0]              bank_done_type,
    input  logic [num_banks*data_width-1:0]   bank_done_data,
    input  logic [num_banks*index_width-1:0]  bank_done_index,
    output logic [num_banks-1:0]              bank_done_ready,
    output logic                              request_done_valid,
    output logic                              the_type,
    output logic [data_width-1:0]             data_in,
    output logic [index_width-1:0]            index,
    output logic [num_banks-1:0]              pending
);

    import types_def::*;

    localparam int ptr_width = $clog2(num_banks);

    typedef struct packed {
        logic                   req_type;
        logic [data_width-1:0]  data;
        logic [index_width-1:0] index;
    } slot_t;

    generate
        if (index_width != read_entries_log) begin : g_bad_index_width
            $fatal(1, "index_width must equal read_entries_log");
        end
        if (!is_pow2(num_banks) || num_banks < 2) begin : g_bad_num_banks
            $fatal(1, "num_banks must be a power of 2 and at least 2");
        end
    endgenerate

    slot_t                 slot_q [num_banks];
    logic [num_banks-1:0]  held_q;
    logic [ptr_width-1:0]  ptr_q;
    logic [num_banks-1:0]  grant;
    logic [ptr_width-1:0]  grant_idx;
    logic [num_banks-1:0]  capture;
    logic                  any_grant;
    slot_t                 granted;

    rr_arbiter #(
        .N (num_banks),
        .W (ptr_width)
    ) u_rr_arbiter (
        .req       (held_q),
        .ptr       (ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // A slot being drained this cycle may take a new entry on the same edge.
    assign bank_done_ready = ~held_q | grant;
    assign capture         = bank_done_valid & bank_done_ready;
    assign any_grant       = |grant;
    assign granted         = slot_q[grant_idx];
    assign pending         = held_q;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            held_q <= '0;
            ptr_q  <= '0;
            // NOTE: slot contents are reset too; with 16 entries the cost is
            // trivial and it keeps reset state fully deterministic.
            for (int b = 0; b < num_banks; b++) begin
                slot_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < num_banks; b++) begin
                if (capture[b]) begin
                    held_q[b] <= 1'b1;
                    slot_q[b] <= '{
                        req_type: bank_done_type[b],
                        data:     bank_done_data[b*data_width +: data_width],
                        index:    bank_done_index[b*index_width +: index_width]
                    };
                end else if (grant[b]) begin
                    held_q[b] <= 1'b0;
                end
            end
            if (any_grant) begin
                ptr_q <= grant_idx + 1'b1;
            end
        end
    end

    // The returner never stalls, so the output register reloads on every grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            request_done_valid <= 1'b0;
            the_type           <= 1'b0;
            data_in            <= '0;
            index              <= '0;
        end else begin
            request_done_valid <= any_grant;
            if (any_grant) begin
                the_type <= granted.req_type;
                index    <= granted.index;
                data_in  <= (req_type_e'(granted.req_type) == req_write) ? '0 : granted.data;
            end
        end
    end

endmodule

// File: tb/tb_bank_done_arbiter.sv
// Directed bench for bank_done_arbiter with hand-computed expectations.
module tb_bank_done_arbiter;

    localparam int NB = 16;
    localparam int DW = 32;
    localparam int IW = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [NB-1:0]    bank_done_valid;
    logic [NB-1:0]    bank_done_type;
    logic [NB*DW-1:0] bank_done_data;
    logic [NB*IW-1:0] bank_done_index;
    logic [NB-1:0]    bank_done_ready;
    logic             request_done_valid;
    logic             the_type;
    logic [DW-1:0]    data_in;
    logic [IW-1:0]    index;
    logic [NB-1:0]    pending;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    bank_done_arbiter #(
        .data_width  (DW),
        .num_banks   (NB),
        .index_width (IW)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .bank_done_valid    (bank_done_valid),
        .bank_done_type     (bank_done_type),
        .bank_done_data     (bank_done_data),
        .bank_done_index    (bank_done_index),
        .bank_done_ready    (bank_done_ready),
        .request_done_valid (request_done_valid),
        .the_type           (the_type),
        .data_in            (data_in),
        .index              (index),
        .pending            (pending)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bank(input int b, input logic t, input logic [DW-1:0] d, input logic [IW-1:0] ix);
        bank_done_valid[b]          = 1'b1;
        bank_done_type[b]           = t;
        bank_done_data[b*DW +: DW]  = d;
        bank_done_index[b*IW +: IW] = ix;
    endtask

    task automatic check_out(input string tag, input logic t, input logic [DW-1:0] d, input logic [IW-1:0] ix);
        check({tag, ".valid"}, 64'(request_done_valid), 64'd1);
        check({tag, ".type"},  64'(the_type), 64'(t));
        check({tag, ".data"},  64'(data_in), 64'(d));
        check({tag, ".index"}, 64'(index), 64'(ix));
    endtask

    initial begin
        rst             = 1'b1;
        bank_done_valid = '0;
        bank_done_type  = '0;
        bank_done_data  = '0;
        bank_done_index = '0;
        #2;
        check("reset.valid",   64'(request_done_valid), 64'd0);
        check("reset.pending", 64'(pending), 64'd0);
        check("reset.ready",   64'(bank_done_ready), 64'hffff);
        check("reset.data",    64'(data_in), 64'd0);
        check("reset.index",   64'(index), 64'd0);
        check("reset.type",    64'(the_type), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Single read from bank 3.
        set_bank(3, 1'b0, 32'hDEADBEEF, 6'd5);
        tick();
        bank_done_valid = '0;
        check("read.pending", 64'(pending), 64'h0008);
        check("read.early_valid", 64'(request_done_valid), 64'd0);
        tick();
        check_out("read", 1'b0, 32'hDEADBEEF, 6'd5);
        check("read.pending_after", 64'(pending), 64'd0);
        tick();
        check("read.valid_drop", 64'(request_done_valid), 64'd0);
        check("read.data_hold",  64'(data_in), 64'hDEADBEEF);

        // Write from bank 7: data must be masked to zero.
        set_bank(7, 1'b1, 32'h12345678, 6'd9);
        tick();
        bank_done_valid = '0;
        tick();
        check_out("write", 1'b1, 32'd0, 6'd9);

        // Reset pulse returns the pointer to 0 before the full burst.
        tick();
        rst = 1'b1;
        #1;
        rst = 1'b0;
        tick();

        // Full burst: all banks captured on one edge, drained 0..15.
        for (int b = 0; b < NB; b++) begin
            set_bank(b, 1'b0, 32'hA000_0000 + DW'(b), IW'(b));
        end
        tick();
        bank_done_valid = '0;
        check("burst.pending", 64'(pending), 64'hffff);
        check("burst.ready",   64'(bank_done_ready), 64'h0001);
        for (int k = 0; k < NB; k++) begin
            tick();
            check_out($sformatf("burst%0d", k), 1'b0, 32'hA000_0000 + DW'(k), IW'(k));
            check($sformatf("burst%0d.pending", k), 64'(pending),
                  64'(16'(~((32'd1 << (k + 1)) - 1))));
            check($sformatf("burst%0d.ready", k), 64'(bank_done_ready),
                  64'(16'((32'd1 << (k + 2)) - 1)));
        end
        tick();
        check("burst.idle", 64'(request_done_valid), 64'd0);

        // Back-to-back on bank 2: ready stays high, order preserved.
        set_bank(2, 1'b0, 32'h0000_0201, 6'd1);
        tick();
        check("b2b.ready1", 64'(bank_done_ready[2]), 64'd1);
        set_bank(2, 1'b0, 32'h0000_0202, 6'd2);
        tick();
        check_out("b2b1", 1'b0, 32'h0000_0201, 6'd1);
        check("b2b.ready2", 64'(bank_done_ready[2]), 64'd1);
        set_bank(2, 1'b0, 32'h0000_0203, 6'd3);
        tick();
        check_out("b2b2", 1'b0, 32'h0000_0202, 6'd2);
        bank_done_valid = '0;
        tick();
        check_out("b2b3", 1'b0, 32'h0000_0203, 6'd3);
        tick();
        check("b2b.idle", 64'(request_done_valid), 64'd0);

        // Fairness: banks 0 and 15 stream; pointer sits at 3 after bank 2,
        // so bank 15 wins first and the two alternate from there.
        set_bank(0,  1'b0, 32'h0000_F000, 6'd0);
        set_bank(15, 1'b0, 32'h0000_F00F, 6'd15);
        tick();
        tick();
        check_out("fair0", 1'b0, 32'h0000_F00F, 6'd15);
        tick();
        check_out("fair1", 1'b0, 32'h0000_F000, 6'd0);
        tick();
        check_out("fair2", 1'b0, 32'h0000_F00F, 6'd15);
        tick();
        check_out("fair3", 1'b0, 32'h0000_F000, 6'd0);
        bank_done_valid = '0;
        tick();
        check_out("fair4", 1'b0, 32'h0000_F00F, 6'd15);
        tick();
        check_out("fair5", 1'b0, 32'h0000_F000, 6'd0);
        tick();
        check("fair.idle", 64'(request_done_valid), 64'd0);

        // Reset mid-burst with 8 banks held.
        for (int b = 0; b < 8; b++) begin
            set_bank(b, 1'b0, 32'hB000_0000 + DW'(b), IW'(8 + b));
        end
        tick();
        bank_done_valid = '0;
        check("rstmid.pending", 64'(pending), 64'h00ff);
        tick();
        check("rstmid.valid_before", 64'(request_done_valid), 64'd1);
        rst = 1'b1;
        #1;
        check("rstmid.pending0", 64'(pending), 64'd0);
        check("rstmid.valid0",   64'(request_done_valid), 64'd0);
        check("rstmid.ready",    64'(bank_done_ready), 64'hffff);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("rstmid.stale1", 64'(request_done_valid), 64'd0);
        tick();
        check("rstmid.stale2", 64'(request_done_valid), 64'd0);
        check("rstmid.pending_after", 64'(pending), 64'd0);

        // Pointer is back at 0: bank 0 beats bank 5.
        set_bank(0, 1'b0, 32'hC000_0000, 6'h20);
        set_bank(5, 1'b1, 32'hC000_0005, 6'h25);
        tick();
        bank_done_valid = '0;
        tick();
        check_out("ptr0.first", 1'b0, 32'hC000_0000, 6'h20);
        tick();
        check_out("ptr0.second", 1'b1, 32'd0, 6'h25);
        tick();
        check("ptr0.idle", 64'(request_done_valid), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
